// File: rtl/uart_tx_module.sv
// UART serial transmitter: start bit, NB_TX_DATA data bits LSB first, stop period.
// Timing is driven by a 16x oversampling tick; one word is serialized per accepted request.
module uart_tx_module #(
  parameter int NB_TX_DATA  = 8,
  parameter int SB_TX_TICKS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_tx_start,
  input  logic [NB_TX_DATA-1:0] i_tx_data,
  output logic                  o_tx,
  output logic                  o_tx_busy,
  output logic                  o_tx_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TX_TICKS - 1);
  localparam logic [2:0] BIT_LAST  = 3'(NB_TX_DATA - 1);

  state_t                  state, state_next;
  logic [4:0]              tick_cnt, tick_cnt_next;
  logic [2:0]              bit_cnt, bit_cnt_next;
  logic [NB_TX_DATA-1:0]   shift, shift_next;
  logic                    tx, tx_next;
  logic                    done;

  // State, counters, shift register and line register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      tick_cnt <= 5'd0;
      bit_cnt  <= 3'd0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

  // Next-state, datapath updates and the end-of-frame pulse
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    tx_next       = tx;
    done          = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (i_tx_start) begin
          shift_next    = i_tx_data;
          tick_cnt_next = 5'd0;
          tx_next       = 1'b0;
          state_next    = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_next = 5'd0;
            bit_cnt_next  = 3'd0;
            tx_next       = shift[0];
            state_next    = DATA;
          end else begin
            tick_cnt_next = tick_cnt + 5'd1;
          end
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_next = 5'd0;
            shift_next    = {1'b0, shift[NB_TX_DATA-1:1]};
            if (bit_cnt == BIT_LAST) begin
              tx_next    = 1'b1;
              state_next = STOP;
            end else begin
              bit_cnt_next = bit_cnt + 3'd1;
              tx_next      = shift[1];
            end
          end else begin
            tick_cnt_next = tick_cnt + 5'd1;
          end
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (i_tick) begin
          if (tick_cnt == STOP_LAST) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            tick_cnt_next = tick_cnt + 5'd1;
          end
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign o_tx      = tx;
  assign o_tx_busy = (state != IDLE);
  assign o_tx_done = done;

endmodule

// File: tb/tb_uart_tx_module.sv
// Self-checking bench for uart_tx_module: vector table, directed corner sequences and
// randomized traffic scored against a tick-indexed frame model on two parameterizations.
module tb_uart_tx_module;

  localparam int NB  = 8;
  localparam int SB0 = 16;
  localparam int SB1 = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick0, start0, tick1, start1;
  logic [7:0] data0, data1;
  logic       tx0, busy0, done0, tx1, busy1, done1;

  always #5 clk = ~clk;

  uart_tx_module #(.NB_TX_DATA(NB), .SB_TX_TICKS(SB0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick0), .i_tx_start(start0), .i_tx_data(data0),
    .o_tx(tx0), .o_tx_busy(busy0), .o_tx_done(done0)
  );

  uart_tx_module #(.NB_TX_DATA(NB), .SB_TX_TICKS(SB1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick1), .i_tx_start(start1), .i_tx_data(data1),
    .o_tx(tx1), .o_tx_busy(busy1), .o_tx_done(done1)
  );

  // Reference: a frame is the line level per consumed tick; output follows ticks consumed.
  typedef struct {
    bit         active;
    int         cnt;
    int         total;
    bit [191:0] line;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_next(model_t m, logic start, logic [7:0] d, logic tick, int sb);
    model_t r = m;
    if (!r.active) begin
      if (start) begin
        r.active = 1'b1;
        r.cnt    = 0;
        r.total  = 16 * (1 + NB) + sb;
        r.line   = '0;
        for (int i = 0; i < r.total; i++) begin
          if (i < 16) r.line[i] = 1'b0;
          else if (i < 16 * (1 + NB)) r.line[i] = d[(i - 16) / 16];
          else r.line[i] = 1'b1;
        end
      end
    end else if (tick) begin
      r.cnt = r.cnt + 1;
      if (r.cnt == r.total) r.active = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [2:0] model_out(model_t m, logic tick);
    if (!m.active) return 3'b100;
    return {m.line[m.cnt], 1'b1, (tick && (m.cnt == m.total - 1))};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 <= '{default: 0};
      m1 <= '{default: 0};
    end else begin
      m0 <= model_next(m0, start0, data0, tick0, SB0);
      m1 <= model_next(m1, start1, data1, tick1, SB1);
    end
  end

  int tests = 0;
  int fails = 0;
  logic [2:0] s0, s1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are sampled and scored mid-cycle.
  task automatic step();
    @(negedge clk);
    s0 = {tx0, busy0, done0};
    s1 = {tx1, busy1, done1};
    check("sb_dut0", {29'd0, s0}, {29'd0, model_out(m0, tick0)});
    check("sb_dut1", {29'd0, s1}, {29'd0, model_out(m1, tick1)});
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame0(input logic [7:0] d, input int ncyc, input int ign_cyc,
                            output logic [9:0] fr, output int done_at,
                            output int busy_cnt, output int ndone);
    start0 = 1'b1; data0 = d; tick0 = 1'b1;
    step();
    fr = '0; done_at = -1; busy_cnt = 0; ndone = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == ign_cyc) begin
        start0 = 1'b1; data0 = 8'h00;
      end else begin
        start0 = 1'b0;
      end
      step();
      if ((c % 16 == 8) && (c < 160)) fr[c / 16] = s0[2];
      if (s0[1]) busy_cnt++;
      if (s0[0]) begin
        ndone++;
        done_at = c;
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    int         done_at;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [9:0] fr, fr2;
    int done_at, done2, busy_cnt, ndone, gap, low;

    vecs[0] = '{8'hA5, 10'h34A, 160};
    vecs[1] = '{8'h0F, 10'h21E, 160};
    vecs[2] = '{8'h00, 10'h200, 160};
    vecs[3] = '{8'hFF, 10'h3FE, 160};
    vecs[4] = '{8'h55, 10'h2AA, 160};
    vecs[5] = '{8'h3C, 10'h278, 160};

    rst = 1'b0;
    start0 = 1'b0; tick0 = 1'b0; data0 = 8'h00;
    start1 = 1'b0; tick1 = 1'b0; data1 = 8'h00;

    // Reset held with random inputs, then released with no request
    for (int i = 0; i < 6; i++) begin
      start0 = 1'($urandom); tick0 = 1'($urandom); data0 = 8'($urandom);
      start1 = 1'($urandom); tick1 = 1'($urandom); data1 = 8'($urandom);
      step();
      check("reset_dut0", {29'd0, s0}, 32'd4);
      check("reset_dut1", {29'd0, s1}, 32'd4);
    end
    start0 = 1'b0; start1 = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick0 = 1'($urandom); tick1 = 1'($urandom);
      step();
      check("post_reset_idle", {29'd0, s0}, 32'd4);
    end

    // Vector table: one frame each with the tick held high
    for (int v = 0; v < 6; v++) begin
      run_frame0(vecs[v].data, 170, 0, fr, done_at, busy_cnt, ndone);
      check("vec_frame", {22'd0, fr}, {22'd0, vecs[v].frame});
      check("vec_done_cycle", done_at, vecs[v].done_at);
      check("vec_busy_cycles", busy_cnt, 160);
      check("vec_done_count", ndone, 1);
    end

    // Request during a busy frame is ignored
    run_frame0(8'hA5, 200, 50, fr, done_at, busy_cnt, ndone);
    check("ignore_frame", {22'd0, fr}, 32'h34A);
    check("ignore_done_cycle", done_at, 160);
    check("ignore_busy_cycles", busy_cnt, 160);
    check("ignore_done_count", ndone, 1);

    // Back-to-back frames with start held high
    start0 = 1'b1; data0 = 8'h55; tick0 = 1'b1;
    step();
    data0 = 8'h3C;
    fr = '0; fr2 = '0; gap = 0; done_at = -1; done2 = -1; ndone = 0;
    for (int c = 1; c <= 340; c++) begin
      start0 = (c <= 161);
      step();
      if ((c <= 160) && (c % 16 == 8)) fr[c / 16] = s0[2];
      if ((c > 161) && (c < 322) && ((c - 161) % 16 == 8)) fr2[(c - 161) / 16] = s0[2];
      if ((c <= 321) && !s0[1]) gap++;
      if (s0[0]) begin
        ndone++;
        if (done_at < 0) done_at = c; else done2 = c;
      end
    end
    check("b2b_frame1", {22'd0, fr}, 32'h2AA);
    check("b2b_frame2", {22'd0, fr2}, 32'h278);
    check("b2b_idle_gap", gap, 1);
    check("b2b_done1", done_at, 160);
    check("b2b_done2", done2, 321);
    check("b2b_done_count", ndone, 2);

    // Reset asserted during data bit 3 takes effect before the next edge
    start0 = 1'b1; data0 = 8'hA5; tick0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 1; c <= 69; c++) step();
    rst = 1'b0;
    step();
    check("midreset_async", {29'd0, s0}, 32'd4);
    step();
    check("midreset_hold", {29'd0, s0}, 32'd4);
    rst = 1'b1;
    step();
    run_frame0(8'h0F, 170, 0, fr, done_at, busy_cnt, ndone);
    check("after_reset_frame", {22'd0, fr}, 32'h21E);
    check("after_reset_done", done_at, 160);

    // Tick every fourth cycle on the two-stop-bit instance
    start1 = 1'b1; data1 = 8'hFF; tick1 = 1'b0;
    step();
    start1 = 1'b0;
    low = 0; done_at = -1; ndone = 0; busy_cnt = 0;
    for (int c = 1; c <= 720; c++) begin
      tick1 = (c % 4 == 0);
      step();
      if (!s1[2]) low++;
      if (s1[1]) busy_cnt++;
      if (s1[0]) begin
        ndone++;
        done_at = c;
      end
    end
    check("gated_start_bit_len", low, 64);
    check("gated_done_cycle", done_at, 704);
    check("gated_done_count", ndone, 1);
    check("gated_busy_cycles", busy_cnt, 704);

    // Randomized traffic, including occasional resets, scored every cycle
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(0, 599) != 0);
      start0 = ($urandom_range(0, 29) == 0);
      data0  = 8'($urandom);
      tick0  = ($urandom_range(0, 3) != 0);
      start1 = ($urandom_range(0, 29) == 0);
      data1  = 8'($urandom);
      tick1  = 1'($urandom);
      step();
    end
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
